// File: rtl/press_decoder.sv
// Classifies debounced button gestures into short, long and double presses.
// Optional auto-repeat while a long press is held: define AUTO_REPEAT_EN.
module press_decoder #(
  parameter int TICK_CYCLES  = 50000,
  parameter int LONG_TICKS   = 800,
  parameter int GAP_TICKS    = 250,
  parameter int REPEAT_TICKS = 200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clean_in,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic repeat_press,
  output logic busy
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int LG = (LONG_TICKS > GAP_TICKS) ? LONG_TICKS : GAP_TICKS;
  localparam int TM = (LG > REPEAT_TICKS) ? LG : REPEAT_TICKS;
  localparam int TW = $clog2(TM + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0] LONG_T     = TW'(LONG_TICKS);
  localparam logic [TW-1:0] GAP_T      = TW'(GAP_TICKS);

  typedef enum logic [2:0] {
    S_WAIT_REL,
    S_IDLE,
    S_PRESS1,
    S_WAIT_GAP,
    S_PRESS2,
    S_LONG_HELD
  } state_t;

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [TW-1:0] tcnt_q;
  logic          short_q;
  logic          long_q;
  logic          double_q;
  logic          repeat_q;
  logic          busy_q;
  logic          tick;
  logic          cnt_en;

  assign tick = (presc_q == PRESC_LAST);

`ifdef AUTO_REPEAT_EN
  localparam logic [TW-1:0] REP_LAST = TW'(REPEAT_TICKS - 1);
  logic rep_q;

  assign cnt_en = (state_q == S_PRESS1) || (state_q == S_WAIT_GAP) ||
                  (state_q == S_PRESS2) ||
                  ((state_q == S_LONG_HELD) && rep_q);
`else
  assign cnt_en = (state_q == S_PRESS1) || (state_q == S_WAIT_GAP) ||
                  (state_q == S_PRESS2);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_WAIT_REL;
      presc_q  <= '0;
      tcnt_q   <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b1;
`ifdef AUTO_REPEAT_EN
      rep_q    <= 1'b0;
`endif
    end else begin
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      repeat_q <= 1'b0;
      // Counters only run in states that time something.
      if (cnt_en) begin
        if (tick) begin
          presc_q <= '0;
          tcnt_q  <= tcnt_q + 1'b1;
        end else begin
          presc_q <= presc_q + 1'b1;
        end
      end else begin
        presc_q <= '0;
        tcnt_q  <= '0;
      end
      unique case (state_q)
        S_WAIT_REL: begin
          if (!clean_in) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (clean_in) begin
            state_q <= S_PRESS1;
            busy_q  <= 1'b1;
            presc_q <= '0;
            tcnt_q  <= '0;
          end
        end
        S_PRESS1: begin
          if (!clean_in) begin
            state_q <= S_WAIT_GAP;
            presc_q <= '0;
            tcnt_q  <= '0;
          end else if (tcnt_q == LONG_T) begin
            state_q <= S_LONG_HELD;
            long_q  <= 1'b1;
            presc_q <= '0;
            tcnt_q  <= '0;
`ifdef AUTO_REPEAT_EN
            rep_q   <= 1'b1;
`endif
          end
        end
        S_WAIT_GAP: begin
          if (clean_in) begin
            state_q <= S_PRESS2;
            presc_q <= '0;
            tcnt_q  <= '0;
          end else if (tcnt_q == GAP_T) begin
            state_q <= S_IDLE;
            short_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_PRESS2: begin
          if (!clean_in) begin
            state_q  <= S_IDLE;
            double_q <= 1'b1;
            busy_q   <= 1'b0;
          end else if (tcnt_q == LONG_T) begin
            state_q  <= S_LONG_HELD;
            double_q <= 1'b1;
            presc_q  <= '0;
            tcnt_q   <= '0;
`ifdef AUTO_REPEAT_EN
            rep_q    <= 1'b0;
`endif
          end
        end
        S_LONG_HELD: begin
          if (!clean_in) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
`ifdef AUTO_REPEAT_EN
          else if (rep_q && tick && (tcnt_q == REP_LAST)) begin
            repeat_q <= 1'b1;
            presc_q  <= '0;
            tcnt_q   <= '0;
          end
`endif
        end
        default: begin
          state_q <= S_WAIT_REL;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = double_q;
  assign repeat_press = repeat_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_press_decoder.sv
// Bench for press_decoder: directed gestures plus random presses
// against a cycle-count reference model.
module tb_press_decoder;

  localparam int T = 4;
  localparam int L = 10;
  localparam int G = 5;
  localparam int R = 3;
`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clean_in = 1'b0;
  logic short_press, long_press, double_press, repeat_press, busy;

  press_decoder #(
    .TICK_CYCLES(T), .LONG_TICKS(L), .GAP_TICKS(G), .REPEAT_TICKS(R)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clean_in(clean_in),
    .short_press(short_press), .long_press(long_press),
    .double_press(double_press), .repeat_press(repeat_press),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // model: phase + cycles elapsed in that phase
  string ph = "WREL";
  int el = 0;
  bit rep_ok = 0;
  bit e_s, e_l, e_d, e_r, e_b = 1;

  int n_s, n_l, n_d, n_r;
  int t_s, t_l, t_d;

  task automatic model_edge(input bit rn, input bit c);
    string nx;
    e_s = 0; e_l = 0; e_d = 0; e_r = 0;
    if (!rn) begin
      ph = "WREL"; el = 0; rep_ok = 0; e_b = 1;
      return;
    end
    el++;
    nx = ph;
    if (ph == "WREL") begin
      if (!c) nx = "IDLE";
    end else if (ph == "IDLE") begin
      if (c) nx = "P1";
    end else if (ph == "P1") begin
      if (!c) nx = "GAP";
      else if (el > L * T) begin nx = "HELD"; e_l = 1; rep_ok = 1; end
    end else if (ph == "GAP") begin
      if (c) nx = "P2";
      else if (el > G * T) begin nx = "IDLE"; e_s = 1; end
    end else if (ph == "P2") begin
      if (!c) begin nx = "IDLE"; e_d = 1; end
      else if (el > L * T) begin nx = "HELD"; e_d = 1; rep_ok = 0; end
    end else begin
      if (!c) nx = "IDLE";
      else if (AR && rep_ok && el == R * T) begin e_r = 1; el = 0; end
    end
    if (nx != ph) el = 0;
    ph = nx;
    e_b = (ph != "IDLE");
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit c, input bit rn = 1'b1);
    clean_in = c;
    reset_n = rn;
    @(posedge clk);
    model_edge(rn, c);
    cyc++;
    @(negedge clk);
    chk("short", short_press, e_s);
    chk("long", long_press, e_l);
    chk("double", double_press, e_d);
    chk("repeat", repeat_press, e_r);
    chk("busy", busy, e_b);
    if (short_press === 1'b1) begin n_s++; t_s = cyc; end
    if (long_press === 1'b1) begin n_l++; t_l = cyc; end
    if (double_press === 1'b1) begin n_d++; t_d = cyc; end
    if (repeat_press === 1'b1) n_r++;
  endtask

  task automatic run(input bit c, input int n);
    for (int i = 0; i < n; i++) step(c);
  endtask

  task automatic clr;
    n_s = 0; n_l = 0; n_d = 0; n_r = 0;
    t_s = -1; t_l = -1; t_d = -1;
  endtask

  int t0;

  initial begin
    clr();
    step(0, 0);
    step(0, 0);
    run(0, 3);

    // short press
    clr();
    run(1, 12);
    t0 = cyc + 1;
    run(0, 30);
    chk_int("short_count", n_s, 1);
    chk_int("short_latency", t_s - t0, 21);
    chk_int("short_others", n_l + n_d + n_r, 0);

    // long press
    clr();
    t0 = cyc + 1;
    run(1, 60);
    run(0, 5);
    chk_int("long_count", n_l, 1);
    chk_int("long_latency", t_l - t0, 41);
    chk_int("long_repeats", n_r, AR ? 1 : 0);
    chk_int("long_no_short", n_s + n_d, 0);

    // double press
    clr();
    run(1, 8);
    run(0, 10);
    run(1, 8);
    t0 = cyc + 1;
    run(0, 30);
    chk_int("dbl_count", n_d, 1);
    chk_int("dbl_latency", t_d - t0, 0);
    chk_int("dbl_no_short", n_s, 0);

    // release exactly on long expiry edge
    clr();
    run(1, 41);
    run(0, 30);
    chk_int("rel_race_long", n_l, 0);
    chk_int("rel_race_short", n_s, 1);

    // press exactly on gap expiry edge
    clr();
    run(1, 8);
    run(0, 21);
    run(1, 8);
    run(0, 30);
    chk_int("gap_race_short", n_s, 0);
    chk_int("gap_race_dbl", n_d, 1);

    // held through reset
    clr();
    clean_in = 1'b1;
    step(1, 0);
    run(1, 30);
    chk("held_busy", busy, 1'b1);
    run(0, 3);
    run(1, 8);
    run(0, 30);
    chk_int("held_pulses", n_l + n_d + n_r, 0);
    chk_int("held_short", n_s, 1);

    // reset mid PRESS1
    clr();
    run(1, 20);
    step(1, 0);
    chk("rst_short", short_press, 1'b0);
    chk("rst_long", long_press, 1'b0);
    chk("rst_busy", busy, 1'b1);
    run(1, 60);
    run(0, 30);
    chk_int("rst_no_long", n_l, 0);

    // random gestures
    for (int g = 0; g < 40; g++) begin
      run(1, $urandom_range(1, 55));
      run(0, $urandom_range(1, 30));
    end
    run(0, 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/press_decoder.md
Name: press_decoder

Overview:
- Consumes the clean, debounced button level produced by the debouncer in the same clock domain.
- Classifies each press gesture as short, long or double press, and emits a one-cycle pulse for each.
- Sits between the input-conditioning stage and the control logic; it is the receiving end of the debounced-level interface.
- Contains an internal tick prescaler plus a tick counter that time the press and gap windows.

Parameters:
- TICK_CYCLES, 50000: clock cycles per tick (1 ms at 50 MHz); must be >= 1.
- LONG_TICKS, 800: hold duration, in ticks, that qualifies a long press; must be >= 1.
- GAP_TICKS, 250: maximum release gap, in ticks, between two presses forming a double press; must be >= 1.
- REPEAT_TICKS, 200: auto-repeat period in ticks; used only with AUTO_REPEAT_EN.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous, active-low reset.
- clean_in  input  1  debounced button level, 1 = pressed, synchronous to clk.
- short_press  output  1  one-cycle pulse on a completed short press.
- long_press  output  1  one-cycle pulse when a hold reaches LONG_TICKS.
- double_press  output  1  one-cycle pulse on a completed double press.
- repeat_press  output  1  one-cycle auto-repeat pulse; constant 0 without AUTO_REPEAT_EN.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Interface rules (already decided): single clock clk; reset_n is synchronous and active-low. No asynchronous logic.
- Reset (reset_n = 0 at a clk edge):
  - state = WAIT_REL; prescaler and tick count = 0.
  - All pulse outputs = 0; busy = 1.
  - Reset mid-gesture aborts the gesture with no pulse.
- Timing base:
  - Prescaler counts 0..TICK_CYCLES-1 and produces a one-cycle tick at wrap.
  - Tick count increments on each tick.
  - Every state transition clears both the prescaler and the tick count, so N ticks after entering a state is exactly N*TICK_CYCLES cycles.
  - Counter widths are $clog2 of (max terminal value + 1); no wrap is possible inside a state.
- States and transitions (all evaluated at the clk edge; all outputs registered):
  - WAIT_REL: clean_in = 0 -> IDLE. This prevents a button held through reset from being decoded.
  - IDLE: clean_in = 1 -> PRESS1.
  - PRESS1:
    - clean_in = 0 -> WAIT_GAP.
    - Otherwise, tick count reaching LONG_TICKS -> LONG_HELD with long_press = 1.
  - WAIT_GAP:
    - clean_in = 1 -> PRESS2.
    - Otherwise, tick count reaching GAP_TICKS -> IDLE with short_press = 1.
  - PRESS2:
    - clean_in = 0 -> IDLE with double_press = 1.
    - Tick count reaching LONG_TICKS while held -> LONG_HELD with double_press = 1; long_press is not asserted.
  - LONG_HELD: clean_in = 0 -> IDLE.
- Pulse timing: each pulse is high for exactly the one cycle following the transition edge, and at most one pulse is high per cycle.
- Simultaneous events:
  - Release on the same edge as the LONG_TICKS expiry: release wins (PRESS1 -> WAIT_GAP, no long_press).
  - Press on the same edge as the GAP_TICKS expiry: press wins (-> PRESS2, no short_press).
- Latency:
  - short_press is reported GAP_TICKS*TICK_CYCLES+1 cycles after the release edge.
  - long_press is reported LONG_TICKS*TICK_CYCLES+1 cycles after PRESS1 entry.
- busy = (state != IDLE), registered.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - Only when LONG_HELD is entered from PRESS1, repeat_press pulses one cycle each time the tick count reaches REPEAT_TICKS while clean_in = 1.
  - The count clears after each pulse, giving a period of REPEAT_TICKS*TICK_CYCLES cycles.
  - LONG_HELD entered from PRESS2 never repeats.
- Undefined: no repeat counter logic; repeat_press is tied to 0.

Test Plan:
- Bench parameters for every scenario: TICK_CYCLES=4, LONG_TICKS=10, GAP_TICKS=5, REPEAT_TICKS=3.
- Hold clean_in=1 for 12 cycles, then 0 -> short_press is one pulse, 21 cycles after the release edge; no other pulses.
- Hold clean_in=1 for 60 cycles -> long_press pulses 41 cycles after PRESS1 entry; with AUTO_REPEAT_EN, repeat_press pulses every 12 cycles after that while held; no pulse on release.
- Press 8 cycles, release 10 cycles, press 8 cycles, release -> double_press pulses one cycle after the second release; short_press stays 0.
- Release exactly on the LONG_TICKS expiry edge -> no long_press; short_press follows. Press exactly on the GAP_TICKS expiry edge -> no short_press; double_press follows on release.
- Hold clean_in=1 across reset deassertion for 30 cycles -> no pulses and busy=1 until release; a later 8-cycle press yields short_press.
- Assert reset_n=0 for 1 cycle midway through PRESS1 (cycle 20) -> all outputs 0, and no long_press ever fires for that hold.
